// File: rtl/noc_input_unit.sv
// -----------------------------------------------------------------------------
// noc_input_unit
//
// Input port of a wormhole NoC router. Incoming flits are buffered in a small
// FIFO. When a head flit reaches the front of the FIFO, the route processor's
// answer (route_i, computed from yx_addr_header_o) is latched. The unit then
// requests the output arbiter. Once granted, it streams the packet to the
// crossbar until the tail flit leaves. Any body or tail flit found at the FIFO
// head while no packet is open is dropped, and err_o pulses once.
//
// Flit type encoding in flit[33:32]:
//   00 body, 01 head, 10 tail, 11 head+tail
//
// Ports
//   clk_i, rst_i      clock; asynchronous active-high reset
//   flit_i            upstream flit (type + 32-bit payload)
//   flit_valid_i      upstream flit valid
//   flit_ready_o      FIFO has room for a flit
//   yx_addr_header_o  payload[7:0] of the FIFO-head flit ([7:4] y, [3:0] x)
//   route_i           output-port code from the route processor
//   req_o             request to the output arbiter
//   route_o           output port latched for the current packet
//   grant_i           arbiter grant for this input
//   flit_o            FIFO-head flit to the crossbar
//   flit_valid_o      flit_o valid (only while streaming a granted packet)
//   flit_ready_i      downstream accepts flit_o
//   err_o             one-cycle pulse after a stray flit is discarded
// -----------------------------------------------------------------------------
module noc_input_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [33:0] flit_i,
    input  logic        flit_valid_i,
    output logic        flit_ready_o,
    output logic [7:0]  yx_addr_header_o,
    input  logic [2:0]  route_i,
    output logic        req_o,
    output logic [2:0]  route_o,
    input  logic        grant_i,
    output logic [33:0] flit_o,
    output logic        flit_valid_o,
    input  logic        flit_ready_i,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_ACTIVE = 2'b10
    } state_t;

    // Head and head+tail both open a packet.
    function automatic logic is_head_type(input logic [1:0] flit_type);
        return flit_type[0];
    endfunction

    // Tail and head+tail both close a packet.
    function automatic logic is_tail_type(input logic [1:0] flit_type);
        return flit_type[1];
    endfunction

    logic [33:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    state_t        state_r;
    state_t        state_nxt_s;
    logic [2:0]    route_r;
    logic [2:0]    route_nxt_s;
    logic          req_r;
    logic          err_r;
    logic          err_nxt_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          stray_pop_s;
    logic          active_pop_s;
    logic          flit_valid_s;
    logic [33:0]   head_s;

    assign full_s  = (count_r == FULL_COUNT);
    assign empty_s = (count_r == {CW{1'b0}});
    assign head_s  = mem_r[rd_ptr_r];

    // A full FIFO never accepts a flit, even if a pop happens in the same cycle.
    assign push_s = flit_valid_i && !full_s;
    assign pop_s  = stray_pop_s || active_pop_s;

    // FIFO storage write. The data array needs no reset because count_r
    // qualifies every read.
    always_ff @(posedge clk_i) begin
        if (push_s && !rst_i) begin
            mem_r[wr_ptr_r] <= flit_i;
        end
    end

    // FIFO read/write pointers and occupancy count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Packet FSM: next-state, route latch, stray discard and streaming pop.
    always_comb begin
        state_nxt_s  = state_r;
        route_nxt_s  = route_r;
        err_nxt_s    = 1'b0;
        stray_pop_s  = 1'b0;
        active_pop_s = 1'b0;
        flit_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    if (is_head_type(head_s[33:32])) begin
                        // route_i answers for the current yx_addr_header_o.
                        route_nxt_s = route_i;
                        state_nxt_s = ST_REQ;
                    end else begin
                        stray_pop_s = 1'b1;
                        err_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (grant_i) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_ACTIVE: begin
                // An empty FIFO here just stalls until the rest of the packet arrives.
                flit_valid_s = !empty_s;
                if (!empty_s && flit_ready_i) begin
                    active_pop_s = 1'b1;
                    if (is_tail_type(head_s[33:32])) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_ACTIVE;
                    end
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched route, registered request and error pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            route_r <= 3'b000;
            req_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            route_r <= route_nxt_s;
            // req_o is high in every state except IDLE. It is registered
            // from the next state, so it drops as the tail pops.
            req_r   <= (state_nxt_s != ST_IDLE);
            err_r   <= err_nxt_s;
        end
    end

    assign flit_ready_o     = !full_s;
    assign yx_addr_header_o = head_s[7:0];
    assign flit_o           = head_s;
    assign flit_valid_o     = flit_valid_s;
    assign req_o            = req_r;
    assign route_o          = route_r;
    assign err_o            = err_r;

endmodule

// File: doc/noc_input_unit.md
NOC_INPUT_UNIT -- requirements
Module: noc_input_unit

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in flits; power of two, >= 2.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 flit_i  input  34  upstream flit: [33:32] type (00 body, 01 head, 10 tail, 11 head+tail), [31:0] payload.
REQ-005 flit_valid_i  input  1  upstream flit valid.
REQ-006 flit_ready_o  output  1  FIFO can accept a flit.
REQ-007 yx_addr_header_o  output  8  destination address to the YX route processor: payload[7:0] of the FIFO-head flit; [7:4] y, [3:0] x.
REQ-008 route_i  input  3  output-port code returned combinationally by the YX route processor.
REQ-009 req_o  output  1  request to the output arbiter for port route_o.
REQ-010 route_o  output  3  latched output-port code for the current packet.
REQ-011 grant_i  input  1  arbiter grant for this input.
REQ-012 flit_o  output  34  FIFO-head flit to the crossbar.
REQ-013 flit_valid_o  output  1  flit_o valid.
REQ-014 flit_ready_i  input  1  crossbar/downstream accepts flit_o.
REQ-015 err_o  output  1  one-cycle pulse: stray non-head flit discarded.

Function
REQ-016 Push occurs when flit_valid_i && flit_ready_o; flit_ready_o = !full; no write-through when full, even if a pop occurs in the same cycle.
REQ-017 Pop occurs when flit_valid_o && flit_ready_i, or on a stray discard (REQ-021); push and pop in the same cycle leave the count unchanged.
REQ-018 The FIFO uses wrap-around read/write pointers plus a count of width log2(DEPTH)+1; full = (count == DEPTH), empty = (count == 0).
REQ-019 yx_addr_header_o = FIFO-head payload[7:0] at all times (combinational); the value is don't-care when the FIFO is empty.
REQ-020 FSM states: IDLE, REQ, ACTIVE.
REQ-021 In IDLE, if the FIFO is non-empty and the head type is body or tail: pop the flit, pulse err_o for one cycle, and remain in IDLE.
REQ-022 In IDLE, if the FIFO is non-empty and the head type is head or head+tail: latch route_i into route_o and go to REQ; nothing is popped.
REQ-023 In REQ: req_o = 1; grant_i is sampled; if grant_i = 1, go to ACTIVE next cycle.
REQ-024 In ACTIVE: req_o = 1 and flit_valid_o = !empty; when a popped flit is tail or head+tail, go to IDLE next cycle, with req_o deasserting that cycle.
REQ-025 grant_i is ignored in IDLE and ACTIVE; the arbiter holds its grant while req_o is high.
REQ-026 flit_valid_o = 0 outside ACTIVE; flit_o always equals the FIFO head.
REQ-027 route_o is held from IDLE->REQ until the next latch; route_i is never re-sampled mid-packet.
REQ-028 Minimum latency: head pushed at edge N; route latched at N+1; req_o high during cycle N+1..; with grant at N+1, flit_valid_o high during cycle N+2.
REQ-029 A packet's body flits may arrive while in REQ or ACTIVE; FIFO empty in ACTIVE stalls (flit_valid_o = 0) with the state unchanged.

Reset
REQ-030 On rst_i assertion, immediately: state IDLE, pointers/count 0, route_o 0, req_o 0, flit_valid_o 0, err_o 0, flit_ready_o 1.
REQ-031 Reset mid-packet discards all buffered flits; the first flit after reset is treated per REQ-021/022.
REQ-032 No push, pop or state change occurs while rst_i is high.

Verification
REQ-033 Single flit: type 11, payload[7:0]=8'h33, route_i=3'b010, grant at first req_o cycle -> yx_addr_header_o=8'h33, route_o=3'b010, one flit out, return to IDLE, req_o low.
REQ-034 4-flit packet (head 8'h21, 2 body, tail), flit_ready_i toggling 1/0 -> flits out in order, no loss/dup, req_o high from route latch through the tail pop.
REQ-035 Fill: DEPTH+2 flits offered, grant withheld -> flit_ready_o=0 after 4 pushes, count=4, then drains in order once granted.
REQ-036 Stray body flit in IDLE -> err_o pulses exactly one cycle, flit dropped, following head routed normally.
REQ-037 Back-to-back packets (tail then head same stream) -> second head re-samples route_i, new route_o, IDLE visited one cycle.
REQ-038 rst_i asserted mid-packet with 3 flits buffered -> outputs per REQ-030 immediately; after release, flit_ready_o=1 and FIFO empty.
